idecode: RTL

IDECODE -- requirements
Module: idecode

---
 rtl/idecode_pkg.sv | 26 ++
 rtl/idecode_if.sv | 12 +
 rtl/idecode_registerfile.sv | 37 +++
 rtl/idecode.sv | 87 ++++++++
 4 files changed

// File: rtl/idecode_pkg.sv
// Shared instruction-format definitions (package bexkat1Def): field slices and the long-form flag bit.
// Optional read bypass in the register file is selected by BEXKAT1_RF_BYPASS_EN.
package bexkat1Def;

  localparam int IR_W        = 64;
  localparam int TYPE_HI     = 31;
  localparam int TYPE_LO     = 28;
  localparam int OPCODE_HI   = 27;
  localparam int OPCODE_LO   = 24;
  localparam int RA_HI       = 23;
  localparam int RA_LO       = 20;
  localparam int RB_HI       = 19;
  localparam int RB_LO       = 16;
  localparam int RC_HI       = 15;
  localparam int RC_LO       = 12;
  localparam int LONG_BIT    = 0;

  // Long form carries a full 32-bit immediate in the upper word; short form packs 15 bits above the flag.
  function automatic logic [31:0] decode_imm(input logic [IR_W-1:0] ir);
    if (ir[LONG_BIT])
      return ir[63:32];
    else
      return {{17{ir[15]}}, ir[15:1]};
  endfunction

endpackage

// File: rtl/idecode_if.sv
// Writeback bus into the decode stage register file.
// wb_we_i qualifies wb_addr_i/wb_data_i in the same cycle; there is no backpressure, the write always lands.
interface idecode_if #(
  parameter int RF_AWIDTH = 4
);
  logic                 wb_we_i;
  logic [RF_AWIDTH-1:0] wb_addr_i;
  logic [31:0]          wb_data_i;

  modport master (output wb_we_i, wb_addr_i, wb_data_i);
  modport slave  (input  wb_we_i, wb_addr_i, wb_data_i);
endinterface

// File: rtl/idecode_registerfile.sv
// Register file: two asynchronous read ports, one synchronous write port, all entries cleared on reset.
// Defining BEXKAT1_RF_BYPASS_EN makes a same-cycle write visible on the read ports (write-first).
module registerfile #(
  parameter int RF_AWIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [RF_AWIDTH-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [RF_AWIDTH-1:0] raddr_a_i,
  input  logic [RF_AWIDTH-1:0] raddr_b_i,
  output logic [31:0]          rdata_a_o,
  output logic [31:0]          rdata_b_o
);

  localparam int DEPTH = 2 ** RF_AWIDTH;

  logic [31:0] regs [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we_i) begin
      regs[waddr_i] <= wdata_i;
    end
  end

`ifdef BEXKAT1_RF_BYPASS_EN
  assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs[raddr_a_i];
  assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs[raddr_b_i];
`else
  assign rdata_a_o = regs[raddr_a_i];
  assign rdata_b_o = regs[raddr_b_i];
`endif

endmodule

// File: rtl/idecode.sv
// Instruction decode stage: one registered stage with flush, hold, load-use hazard bubble and register read.
// Register file read bypass is enabled by defining BEXKAT1_RF_BYPASS_EN.
module idecode
  import bexkat1Def::*;
#(
  parameter int RF_AWIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [63:0]          ir_i,
  input  logic [31:0]          pc_i,
  input  logic                 pc_set_i,
  input  logic                 stall_i,
  output logic                 stall_o,
  input  logic                 exe_we_i,
  input  logic                 mem_we_i,
  input  logic [RF_AWIDTH-1:0] exe_dst_i,
  input  logic [RF_AWIDTH-1:0] mem_dst_i,
  idecode_if.slave             wb,
  output logic [63:0]          ir_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          a_val_o,
  output logic [31:0]          b_val_o,
  output logic [31:0]          imm_o,
  output logic [RF_AWIDTH-1:0] dst_o,
  output logic                 valid_o
);

  logic [RF_AWIDTH-1:0] ra, rb, rc;
  logic [31:0]          rf_a, rf_b;
  logic                 ir_live;
  logic                 exe_hit, mem_hit, hazard;

  assign ra = RF_AWIDTH'(ir_i[RA_HI:RA_LO]);
  assign rb = RF_AWIDTH'(ir_i[RB_HI:RB_LO]);
  assign rc = RF_AWIDTH'(ir_i[RC_HI:RC_LO]);

  // A bubble has no real sources, so it must never raise a hazard.
  assign ir_live = (ir_i != '0);
  assign exe_hit = exe_we_i && ((exe_dst_i == rb) || (exe_dst_i == rc));
  assign mem_hit = mem_we_i && ((mem_dst_i == rb) || (mem_dst_i == rc));
  assign hazard  = ir_live && (exe_hit || mem_hit);
  assign stall_o = hazard && !pc_set_i;

  registerfile #(.RF_AWIDTH(RF_AWIDTH)) u_rf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wb.wb_we_i),
    .waddr_i   (wb.wb_addr_i),
    .wdata_i   (wb.wb_data_i),
    .raddr_a_i (rb),
    .raddr_b_i (rc),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  // Priority: flush > hold > hazard bubble > advance. Held operands stay frozen even if wb rewrites the source.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_o    <= '0;
      pc_o    <= '0;
      a_val_o <= '0;
      b_val_o <= '0;
      imm_o   <= '0;
      dst_o   <= '0;
      valid_o <= 1'b0;
    end else if (pc_set_i) begin
      ir_o    <= '0;
      valid_o <= 1'b0;
    end else if (stall_i) begin
      ir_o    <= ir_o;
      valid_o <= valid_o;
    end else if (hazard) begin
      ir_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      ir_o    <= ir_i;
      pc_o    <= pc_i;
      a_val_o <= rf_a;
      b_val_o <= rf_b;
      imm_o   <= decode_imm(ir_i);
      dst_o   <= ra;
      valid_o <= ir_live;
    end
  end

endmodule
